// File: rtl/ball_motion_ctrl.sv
// Pong ball motion / collision-response controller: serve countdown, per-frame movement, wall and paddle bounces, score exits.
// Optional feature macro BALL_SPEEDUP_EN: each accepted paddle reflection raises the step size, saturating at 2*SPEED.
module ball_motion_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 64,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       collide_l,
    input  logic       collide_r,
    input  logic       serve,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       score_l,
    output logic       score_r,
    output logic       in_play
);

    localparam int CW = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0]  CENTRE_X = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CENTRE_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]  BOTTOM_Y = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);
    localparam logic [10:0] SCR_W    = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H    = 11'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        SCORED
    } state_t;

    state_t        state;
    logic [CW-1:0] countdown;
    logic          hit_l;
    logic          hit_r;
    logic [10:0]   step;

`ifdef BALL_SPEEDUP_EN
    localparam int SW = $clog2(2 * SPEED + 1);
    localparam logic [SW-1:0] SPEED_MIN = SW'(SPEED);
    localparam logic [SW-1:0] SPEED_MAX = SW'(2 * SPEED);
    logic [SW-1:0] speed;
    assign step = 11'(speed);
`else
    assign step = 11'(SPEED);
`endif

    logic        hit_l_now;
    logic        hit_r_now;
    logic        refl_l;
    logic        refl_r;
    logic        next_dir_x;
    logic [10:0] x_wide;
    logic [10:0] y_wide;
    logic [9:0]  next_y;
    logic        next_dir_y;
    logic [9:0]  next_x;
    logic        exit_left_scores;
    logic        exit_right_scores;

    // A collide on the frame_tick cycle itself counts toward this frame's reflection.
    always_comb begin
        hit_l_now  = hit_l | collide_l;
        hit_r_now  = hit_r | collide_r;
        refl_l     = hit_l_now & ~dir_x;
        refl_r     = hit_r_now & dir_x;
        next_dir_x = dir_x;
        if (refl_l) begin
            next_dir_x = 1'b1;
        end
        if (refl_r) begin
            next_dir_x = 1'b0;
        end

        x_wide     = {1'b0, ball_x};
        y_wide     = {1'b0, ball_y};
        next_y     = ball_y;
        next_dir_y = dir_y;
        if (!dir_y && (y_wide < step)) begin
            next_y     = 10'd0;
            next_dir_y = 1'b1;
        end else if (dir_y && (y_wide + BALL_W + step > SCR_H)) begin
            next_y     = BOTTOM_Y;
            next_dir_y = 1'b0;
        end else if (dir_y) begin
            next_y = 10'(y_wide + step);
        end else begin
            next_y = 10'(y_wide - step);
        end

        exit_right_scores = !next_dir_x && (x_wide < step);
        exit_left_scores  = next_dir_x && (x_wide + BALL_W + step > SCR_W);
        next_x = next_dir_x ? 10'(x_wide + step) : 10'(x_wide - step);
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            countdown <= '0;
            hit_l     <= 1'b0;
            hit_r     <= 1'b0;
            ball_x    <= CENTRE_X;
            ball_y    <= CENTRE_Y;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            score_l   <= 1'b0;
            score_r   <= 1'b0;
            in_play   <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            speed     <= SPEED_MIN;
`endif
        end else begin
            score_l <= 1'b0;
            score_r <= 1'b0;
            case (state)
                IDLE: begin
                    hit_l <= 1'b0;
                    hit_r <= 1'b0;
                    if (serve) begin
                        countdown <= CW'(SERVE_FRAMES);
                        state     <= SERVE_WAIT;
`ifdef BALL_SPEEDUP_EN
                        speed     <= SPEED_MIN;
`endif
                    end
                end
                SERVE_WAIT: begin
                    hit_l <= 1'b0;
                    hit_r <= 1'b0;
                    if (frame_tick) begin
                        countdown <= countdown - CW'(1);
                        if (countdown == CW'(1)) begin
                            state   <= PLAY;
                            in_play <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        hit_l  <= 1'b0;
                        hit_r  <= 1'b0;
                        dir_x  <= next_dir_x;
                        ball_y <= next_y;
                        dir_y  <= next_dir_y;
`ifdef BALL_SPEEDUP_EN
                        if ((refl_l || refl_r) && (speed < SPEED_MAX)) begin
                            speed <= speed + SW'(1);
                        end
`endif
                        if (exit_left_scores) begin
                            score_l <= 1'b1;
                            in_play <= 1'b0;
                            state   <= SCORED;
                        end else if (exit_right_scores) begin
                            score_r <= 1'b1;
                            in_play <= 1'b0;
                            state   <= SCORED;
                        end else begin
                            ball_x <= next_x;
                        end
                    end else begin
                        hit_l <= hit_l | collide_l;
                        hit_r <= hit_r | collide_r;
                    end
                end
                SCORED: begin
                    // Serve toward the player who conceded: a left score sends the ball right.
                    state  <= IDLE;
                    ball_x <= CENTRE_X;
                    ball_y <= CENTRE_Y;
                    dir_y  <= 1'b1;
                    dir_x  <= score_l;
                    hit_l  <= 1'b0;
                    hit_r  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Ball motion and collision-response controller for Pong. It consumes the per-paddle `collide` flags produced by the two paddle collision detectors. Once per video frame it moves the ball, reflects it off paddles and the top/bottom walls, and detects scoring exits. It drives the `object_x`/`object_y` inputs of the collision detectors and the ball sprite renderer, and issues score pulses to the scoreboard.

## Interface
Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 64, ball bounding-box side (circle diameter)
- SPEED, 2, pixels moved per axis per frame
- SERVE_FRAMES, 60, frames between serve press and ball release

Ports:
- pixel_clk  in  1  pixel clock, sole clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
- collide_l  in  1  left-paddle collision flag
- collide_r  in  1  right-paddle collision flag
- serve  in  1  serve request, level, synchronised upstream
- ball_x  out  10  ball bounding-box left edge
- ball_y  out  10  ball bounding-box top edge
- dir_x  out  1  1 = moving right, 0 = moving left
- dir_y  out  1  1 = moving down, 0 = moving up
- score_l  out  1  one-cycle pulse: left player scored
- score_r  out  1  one-cycle pulse: right player scored
- in_play  out  1  high while state is PLAY

## Operation
- Reset values:
  - Outputs: ball_x = (SCREEN_W-BALL_SIZE)/2 = 288, ball_y = (SCREEN_H-BALL_SIZE)/2 = 208, dir_x = 1, dir_y = 1, score_l = score_r = 0, in_play = 0.
  - Internal: state IDLE, sticky flags cleared, countdown 0.
- FSM:
  - IDLE: ball held at centre. serve=1 loads the countdown with SERVE_FRAMES and moves to SERVE_WAIT.
  - SERVE_WAIT: countdown decrements on each frame_tick. A frame_tick with countdown = 1 moves to PLAY. serve is ignored in this state.
  - PLAY: the ball moves on each frame_tick. An exit moves to SCORED.
  - SCORED: held for one cycle; score_l or score_r is high for that cycle. Then moves to IDLE with the ball re-centred, dir_y = 1, and dir_x pointing toward the player who conceded (left scored → dir_x = 1).
- Collision capture:
  - In PLAY, sticky flags hit_l / hit_r are set by collide_l / collide_r on any cycle.
  - The flags are consumed and cleared on the frame_tick cycle; a collide asserted on that same cycle is included.
  - Outside PLAY, collide inputs are ignored and the flags are held clear.
- PLAY frame update, in order, on one frame_tick:
  1. Paddle reflection. hit_l with dir_x = 0 sets dir_x = 1; hit_r with dir_x = 1 sets dir_x = 0. A hit with the ball already receding is discarded, which prevents double reflection while the ball overlaps a paddle. If both flags are set, both rules are applied.
  2. Vertical.
     - dir_y = 0 and ball_y < SPEED → ball_y = 0, dir_y = 1.
     - dir_y = 1 and ball_y+BALL_SIZE+SPEED > SCREEN_H → ball_y = SCREEN_H-BALL_SIZE, dir_y = 0.
     - Otherwise ball_y ± SPEED.
  3. Horizontal, using the post-reflection dir_x.
     - dir_x = 0 and ball_x < SPEED → right player scores.
     - dir_x = 1 and ball_x+BALL_SIZE+SPEED > SCREEN_W → left player scores.
     - Otherwise ball_x ± SPEED.
     - On an exit, ball_x is not updated.
- Arithmetic: all edge comparisons are done in 11 bits, so the 10-bit positions never wrap.

## Timing
- All outputs are registered.
- Position and direction change on the cycle after frame_tick.
- Score pulse: asserted in the cycle after the exiting frame_tick, for exactly one cycle. The re-centred position appears the cycle after that.
- Serve latency: IDLE→SERVE_WAIT one cycle after serve=1. Ball release after exactly SERVE_FRAMES frame_ticks; the first movement happens on the next frame_tick.
- Reset assertion in any state returns all registers to their reset values immediately (asynchronously), with no score pulse.

## Configuration
- BALL_SPEEDUP_EN defined:
  - An internal speed register starts at SPEED and is reloaded with SPEED on entry to SERVE_WAIT.
  - Each accepted paddle reflection increments it, saturating at 2*SPEED.
  - All steps and wall/exit checks use the current speed.
- BALL_SPEEDUP_EN undefined: the step is the constant SPEED and no speed register exists.

## Test plan
- Serve: reset, serve=1 for 1 cycle, 60 frame_ticks → in_play=1. The next frame_tick moves ball_x 288→290 and ball_y 208→210.
- Bottom wall: PLAY, ball_y=415, dir_y=1, frame_tick → ball_y=416, dir_y=0.
- Paddle reflect:
  - PLAY, ball_x=100, dir_x=0. collide_l pulses mid-frame, then frame_tick → dir_x=1, ball_x=102.
  - Then collide_l held high through the next frame_tick → dir_x stays 1, ball_x=104.
- Right exit: PLAY, ball_x=575, dir_x=1, frame_tick → score_l high for exactly 1 cycle. Then IDLE with ball_x=288, ball_y=208, dir_x=1, and no score_r.
- Simultaneous events: collide_r asserted on the frame_tick cycle with dir_x=1, ball_x=570 → dir_x=0, ball_x=568, no score.
- Reset mid-play: assert reset during SERVE_WAIT and during PLAY → all outputs return to reset values at once; serve is required again.
- Speed-up, BALL_SPEEDUP_EN defined: 3 accepted paddle hits → step sequence 3, 4, 4.
